// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path.
//  - fetch_state_t : fetch sequencer state encoding
//  - FAULT_*       : values reported on fault_code
//  - DEFAULT_*     : default parameter values for pc_fetch_unit
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
    localparam logic [1:0] FAULT_MISALIGN = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

    localparam int          DEFAULT_ADDR_W   = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_MAX_WAIT = 16;

    // Word alignment check on the two low address bits.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection for the EXEC cycle.
// Ports:
//  i_pc_plus4  in  ADDR_W  sequential successor of the current PC
//  i_instr     in  32      latched instruction (jump index / branch immediate)
//  i_branch    in  1       conditional branch
//  i_jump      in  1       j/jal
//  i_pcsrc     in  1       non-sequential PC (jr when jump=0)
//  i_alu_zero  in  1       branch condition
//  i_rs_data   in  32      jr target
//  o_target    out ADDR_W  selected next PC
//  o_misalign  out 1       selected target is not word aligned
//  o_illegal   out 1       branch and pcsrc asserted together
module next_pc_calc
    import mips_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic [ADDR_W-1:0] i_pc_plus4,
    input  logic [31:0]       i_instr,
    input  logic              i_branch,
    input  logic              i_jump,
    input  logic              i_pcsrc,
    input  logic              i_alu_zero,
    input  logic [31:0]       i_rs_data,
    output logic [ADDR_W-1:0] o_target,
    output logic              o_misalign,
    output logic              o_illegal
);

    logic [ADDR_W-1:0] w_jr_target;
    logic [ADDR_W-1:0] w_j_target;
    logic [ADDR_W-1:0] w_br_offset;
    logic [ADDR_W-1:0] w_br_target;
    logic              w_unused_ok;

    assign w_jr_target = i_rs_data[ADDR_W-1:0];
    // Jump keeps the top nibble of the sequential PC (region-relative jump).
    assign w_j_target  = {i_pc_plus4[ADDR_W-1:28], i_instr[25:0], 2'b00};
    assign w_br_offset = {{(ADDR_W-18){i_instr[15]}}, i_instr[15:0], 2'b00};
    // Wraps modulo 2^ADDR_W by construction.
    assign w_br_target = i_pc_plus4 + w_br_offset;
    assign w_unused_ok = &{1'b0, i_instr[31:26]};

    // Priority target select: jr, then j/jal, then taken branch, then sequential.
    always_comb begin
        o_target = i_pc_plus4;
        if (i_pcsrc && !i_jump) begin
            o_target = w_jr_target;
        end else if (i_pcsrc && i_jump) begin
            o_target = w_j_target;
        end else if (i_branch && i_alu_zero) begin
            o_target = w_br_target;
        end else begin
            o_target = i_pc_plus4;
        end
    end

    assign o_misalign = is_misaligned(o_target[1:0]);
    assign o_illegal  = i_branch & i_pcsrc;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer for the single-cycle MIPS core.
// Fetches the word at PC over a req/ready handshake, holds it on o_instr for the
// control unit, then in the EXEC cycle loads the next PC from the control inputs.
// Ports:
//  clk, rst_n           clock, asynchronous active-low reset
//  o_imem_req/addr      fetch request and address (address is the PC)
//  i_imem_ready/rdata   fetch response
//  o_instr/o_instr_valid latched instruction, valid during EXEC
//  i_branch/jump/pcsrc  control-unit PC selection
//  i_alu_zero, i_rs_data branch condition and jr target
//  i_halt               stop after the instruction in EXEC
//  o_pc, o_pc_plus4     current PC and jal link value
//  o_fault, o_fault_code sticky fault and its cause
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0],
    parameter int                MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ready,
    input  logic [31:0]       i_imem_rdata,
    output logic [31:0]       o_instr,
    output logic              o_instr_valid,
    input  logic              i_branch,
    input  logic              i_jump,
    input  logic              i_pcsrc,
    input  logic              i_alu_zero,
    input  logic [31:0]       i_rs_data,
    input  logic              i_halt,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_plus4,
    output logic              o_fault,
    output logic [1:0]        o_fault_code
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_imem_req;
    logic              r_instr_valid;
    logic              r_fault;
    logic [1:0]        r_fault_code;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_target;
    logic              w_misalign;
    logic              w_illegal;

    assign w_pc_plus4 = r_pc + {{(ADDR_W-3){1'b0}}, 3'b100};

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .i_pc_plus4 (w_pc_plus4),
        .i_instr    (r_instr),
        .i_branch   (i_branch),
        .i_jump     (i_jump),
        .i_pcsrc    (i_pcsrc),
        .i_alu_zero (i_alu_zero),
        .i_rs_data  (i_rs_data),
        .o_target   (w_target),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal)
    );

    // Fetch/execute sequencer; req/valid/fault are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0000_0000;
            r_wait_cnt    <= '0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_code  <= FAULT_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (i_imem_ready) begin
                        r_instr       <= i_imem_rdata;
                        r_wait_cnt    <= '0;
                        r_state       <= ST_EXEC;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        // Last permitted waiting cycle without a response.
                        r_state      <= ST_FAULT;
                        r_imem_req   <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_code <= FAULT_TIMEOUT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_EXEC: begin
                    r_instr_valid <= 1'b0;
                    if (w_illegal) begin
                        r_state      <= ST_FAULT;
                        r_fault      <= 1'b1;
                        r_fault_code <= FAULT_ILLEGAL;
                    end else if (w_misalign) begin
                        r_state      <= ST_FAULT;
                        r_fault      <= 1'b1;
                        r_fault_code <= FAULT_MISALIGN;
                    end else begin
                        r_pc <= w_target;
                        if (i_halt) begin
                            r_state <= ST_HALT;
                        end else begin
                            r_state    <= ST_FETCH;
                            r_imem_req <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    // Corrupted state encoding: park in a safe terminal state.
                    r_state       <= ST_FAULT;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_fault       <= 1'b1;
                    r_fault_code  <= FAULT_ILLEGAL;
                end
            endcase
        end
    end

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_pc          = r_pc;
    assign o_pc_plus4    = w_pc_plus4;
    assign o_fault       = r_fault;
    assign o_fault_code  = r_fault_code;

endmodule
